// File: rtl/gcm_stream_feeder.sv
// gcm_stream_feeder: packs a host 32-bit word stream (AAD words, then payload
// words) into 128-bit keep-masked beats for the AEAD core, and issues the core
// start pulse together with the section bit lengths.
module gcm_stream_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_aad_bytes,
    input  logic [LEN_W-1:0] len_pld_bytes,
    output logic             busy,
    output logic             done,
    output logic             core_start,
    output logic [63:0]      len_aad_bits,
    output logic [63:0]      len_pld_bits,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             aad_valid,
    input  logic             aad_ready,
    output logic             aad_last,
    output logic [127:0]     aad_data,
    output logic [15:0]      aad_keep,
    output logic             din_valid,
    input  logic             din_ready,
    output logic             din_last,
    output logic [127:0]     din_data,
    output logic [15:0]      din_keep
);

    typedef enum logic [2:0] {
        IDLE,
        AAD_FILL,
        AAD_SEND,
        PLD_FILL,
        PLD_SEND,
        FIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] rem_aad;
    logic [LEN_W-1:0] rem_pld;
    logic [LEN_W-1:0] cur_rem;
    logic [1:0]       widx;
    logic [127:0]     beat_buf;
    logic [127:0]     data_mask;
    logic [15:0]      keep_mask;
    logic [4:0]       n;
    logic [4:0]       n_plus;
    logic [2:0]       words_needed;
    logic             last_word;
    logic             sec_last;
    logic             word_fire;
    logic             beat_fire;

    // Beat sizing for the section in progress: bytes in this beat, words to
    // collect, keep mask and the matching byte-wide data mask.
    always_comb begin
        cur_rem = rem_pld;
        if (state == AAD_FILL || state == AAD_SEND) begin
            cur_rem = rem_aad;
        end
        n = cur_rem[4:0];
        if (cur_rem >= LEN_W'(16)) begin
            n = 5'd16;
        end
        n_plus       = n + 5'd3;
        words_needed = n_plus[4:2];
        last_word    = ({1'b0, widx} == (words_needed - 3'd1));
        sec_last     = (cur_rem == LEN_W'(n));
        keep_mask    = ~(16'hFFFF >> n);
        for (int i = 0; i < 16; i++) begin
            data_mask[8*i +: 8] = {8{keep_mask[i]}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake / stream outputs decoded from state.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        s_ready    = 1'b0;
        aad_valid  = 1'b0;
        aad_last   = 1'b0;
        aad_data   = '0;
        aad_keep   = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        din_data   = '0;
        din_keep   = '0;
        word_fire  = 1'b0;
        beat_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_aad_bytes != '0) begin
                        state_next = AAD_FILL;
                    end else if (len_pld_bytes != '0) begin
                        state_next = PLD_FILL;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            AAD_FILL, PLD_FILL: begin
                s_ready   = 1'b1;
                word_fire = s_valid;
                if (s_valid && last_word) begin
                    state_next = (state == AAD_FILL) ? AAD_SEND : PLD_SEND;
                end
            end
            AAD_SEND: begin
                aad_valid = 1'b1;
                aad_last  = sec_last;
                aad_data  = beat_buf & data_mask;
                aad_keep  = keep_mask;
                beat_fire = aad_ready;
                if (aad_ready) begin
                    if (!sec_last) begin
                        state_next = AAD_FILL;
                    end else if (rem_pld != '0) begin
                        state_next = PLD_FILL;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            PLD_SEND: begin
                din_valid = 1'b1;
                din_last  = sec_last;
                din_data  = beat_buf & data_mask;
                din_keep  = keep_mask;
                beat_fire = din_ready;
                if (din_ready) begin
                    state_next = sec_last ? FIN : PLD_FILL;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: length latching, core start pulse, word packing and the
    // per-section remaining byte counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_start   <= 1'b0;
            len_aad_bits <= '0;
            len_pld_bits <= '0;
            rem_aad      <= '0;
            rem_pld      <= '0;
            widx         <= '0;
            beat_buf     <= '0;
        end else begin
            core_start <= 1'b0;
            if (state == IDLE && start) begin
                core_start   <= 1'b1;
                len_aad_bits <= {{(64-LEN_W-3){1'b0}}, len_aad_bytes, 3'b000};
                len_pld_bits <= {{(64-LEN_W-3){1'b0}}, len_pld_bytes, 3'b000};
                rem_aad      <= len_aad_bytes;
                rem_pld      <= len_pld_bytes;
                widx         <= '0;
                beat_buf     <= '0;
            end
            if (word_fire) begin
                case (widx)
                    2'd0: beat_buf[127:96] <= s_data;
                    2'd1: beat_buf[95:64]  <= s_data;
                    2'd2: beat_buf[63:32]  <= s_data;
                    default: beat_buf[31:0] <= s_data;
                endcase
                widx <= last_word ? 2'd0 : widx + 2'd1;
            end
            if (beat_fire) begin
                beat_buf <= '0;
                if (state == AAD_SEND) begin
                    rem_aad <= rem_aad - LEN_W'(n);
                end else begin
                    rem_pld <= rem_pld - LEN_W'(n);
                end
            end
        end
    end

endmodule

// File: tb/tb_gcm_stream_feeder.sv
// tb_gcm_stream_feeder: scoreboard bench for gcm_stream_feeder. Expected beats
// are computed from the frame lengths and host byte pattern when a frame is
// started and compared as the DUT hands each beat over.
module tb_gcm_stream_feeder;

    localparam int LEN_W = 16;

    typedef struct {
        bit           ch;
        logic [127:0] data;
        logic [15:0]  keep;
        bit           last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len_aad_bytes;
    logic [LEN_W-1:0] len_pld_bytes;
    logic             busy;
    logic             done;
    logic             core_start;
    logic [63:0]      len_aad_bits;
    logic [63:0]      len_pld_bits;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             aad_valid;
    logic             aad_ready;
    logic             aad_last;
    logic [127:0]     aad_data;
    logic [15:0]      aad_keep;
    logic             din_valid;
    logic             din_ready;
    logic             din_last;
    logic [127:0]     din_data;
    logic [15:0]      din_keep;

    beat_t sb[$];
    int    errors;
    int    checks;
    int    hb;

    gcm_stream_feeder #(.LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .len_aad_bytes (len_aad_bytes),
        .len_pld_bytes (len_pld_bytes),
        .busy          (busy),
        .done          (done),
        .core_start    (core_start),
        .len_aad_bits  (len_aad_bits),
        .len_pld_bits  (len_pld_bits),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .aad_valid     (aad_valid),
        .aad_ready     (aad_ready),
        .aad_last      (aad_last),
        .aad_data      (aad_data),
        .aad_keep      (aad_keep),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .din_last      (din_last),
        .din_data      (din_data),
        .din_keep      (din_keep)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] host_word(input int b);
        host_word = {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    // Push the expected beats of one section; b advances past its padded words.
    task automatic sb_push(input int len, input bit ch, inout int b);
        beat_t e;
        int    nb;
        for (int off = 0; off < len; off += 16) begin
            nb = (len - off > 16) ? 16 : len - off;
            e.ch   = ch;
            e.data = '0;
            for (int j = 0; j < nb; j++) begin
                e.data[127 - 8*j -: 8] = 8'(b + off + j);
            end
            e.keep = ~(16'hFFFF >> nb);
            e.last = (off + nb == len);
            sb.push_back(e);
        end
        b += 4 * ((len + 3) / 4);
    endtask

    // Run one frame: host supplies words on demand, beats are checked against
    // the scoreboard, optional din stall with a stray mid-frame start pulse.
    task automatic do_frame(input int la, input int lp, input int stall, input bit mid_start);
        int           model_b;
        int           drive_b;
        int           words_exp;
        int           words_got;
        int           cs_cnt;
        int           done_cnt;
        int           stall_left;
        bit           stalled;
        bit           fire;
        bit           ch;
        logic [127:0] d;
        logic [15:0]  k;
        bit           l;
        logic [144:0] snap;
        beat_t        e;
        model_b   = hb;
        drive_b   = hb;
        sb.delete();
        sb_push(la, 1'b0, model_b);
        sb_push(lp, 1'b1, model_b);
        words_exp  = (la + 3) / 4 + (lp + 3) / 4;
        words_got  = 0;
        cs_cnt     = 0;
        done_cnt   = 0;
        stall_left = 0;
        stalled    = 1'b0;
        snap       = '0;
        @(negedge clk);
        start         = 1'b1;
        len_aad_bytes = LEN_W'(la);
        len_pld_bytes = LEN_W'(lp);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL core_start_after_start: got %b expected 1", core_start);
        end
        checks++;
        if (len_aad_bits !== 64'(la) * 8 || len_pld_bits !== 64'(lp) * 8) begin
            errors++;
            $display("[TB] FAIL len_bits: got %0d/%0d expected %0d/%0d",
                     len_aad_bits, len_pld_bits, la * 8, lp * 8);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (core_start) cs_cnt++;
            if (done) done_cnt++;
            checks++;
            if ((aad_valid && din_valid) || (s_ready && (aad_valid || din_valid))) begin
                errors++;
                $display("[TB] FAIL exclusivity: aad_valid=%b din_valid=%b s_ready=%b expected at most one",
                         aad_valid, din_valid, s_ready);
            end
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = host_word(drive_b);
                drive_b += 4;
                words_got++;
            end else begin
                s_valid = 1'b0;
            end
            aad_ready = 1'b1;
            din_ready = 1'b1;
            start     = 1'b0;
            if (din_valid && stall > 0 && !stalled) begin
                stalled    = 1'b1;
                stall_left = stall;
                snap       = {din_data, din_keep, din_last};
            end
            if (din_valid && stall_left > 0) begin
                din_ready = 1'b0;
                checks++;
                if ({din_data, din_keep, din_last} !== snap || s_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_stable: got keep=%h last=%b s_ready=%b expected keep=%h last=%b s_ready=0",
                             din_keep, din_last, s_ready, snap[16:1], snap[0]);
                end
                if (mid_start && stall_left == 5) begin
                    start         = 1'b1;
                    len_aad_bytes = LEN_W'(99);
                end
                stall_left--;
            end
            fire = 1'b0;
            if (aad_valid && aad_ready) begin
                fire = 1'b1; ch = 1'b0; d = aad_data; k = aad_keep; l = aad_last;
            end
            if (din_valid && din_ready) begin
                fire = 1'b1; ch = 1'b1; d = din_data; k = din_keep; l = din_last;
            end
            if (fire) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got ch=%0d keep=%h expected no beat", ch, k);
                end else begin
                    e = sb.pop_front();
                    if (ch !== e.ch || d !== e.data || k !== e.keep || l !== e.last) begin
                        errors++;
                        $display("[TB] FAIL beat: got ch=%0d keep=%h last=%b data=%h expected ch=%0d keep=%h last=%b data=%h",
                                 ch, k, l, d, e.ch, e.keep, e.last, e.data);
                    end
                end
            end
            if (done) break;
            @(negedge clk);
        end
        s_valid   = 1'b0;
        start     = 1'b0;
        din_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_done: got busy=%b done=%b expected 0/0", busy, done);
        end
        checks++;
        if (done_cnt != 1 || cs_cnt != 1) begin
            errors++;
            $display("[TB] FAIL pulse_counts: got done=%0d core_start=%0d expected 1/1", done_cnt, cs_cnt);
        end
        checks++;
        if (words_got != words_exp) begin
            errors++;
            $display("[TB] FAIL words_consumed: got %0d expected %0d", words_got, words_exp);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_beats: got %0d left expected 0", sb.size());
        end
        checks++;
        if (len_aad_bits !== 64'(la) * 8) begin
            errors++;
            $display("[TB] FAIL len_held: got %0d expected %0d", len_aad_bits, la * 8);
        end
        hb = drive_b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, core_start, s_ready, aad_valid, din_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, core_start, s_ready, aad_valid, din_valid});
        end
        checks++;
        if ({len_aad_bits, len_pld_bits} !== 128'b0) begin
            errors++;
            $display("[TB] FAIL reset_len: got %h/%h expected 0", len_aad_bits, len_pld_bits);
        end
        checks++;
        if ({aad_data, aad_keep, aad_last, din_data, din_keep, din_last} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got aad_keep=%h din_keep=%h expected 0", aad_keep, din_keep);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (core_start !== 1'b0 || s_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_quiet: got core_start=%b s_ready=%b expected 0/0", core_start, s_ready);
            end
        end
    endtask

    task automatic test_frame();
        $display("[TB] frame aad=20 pld=16");
        do_frame(20, 16, 0, 1'b0);
    endtask

    task automatic test_short_payload();
        $display("[TB] frame aad=0 pld=5");
        do_frame(0, 5, 0, 1'b0);
    endtask

    task automatic test_empty();
        $display("[TB] frame aad=0 pld=0");
        do_frame(0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        $display("[TB] frame aad=0 pld=32 with din stall");
        do_frame(0, 32, 10, 1'b1);
    endtask

    task automatic test_reset_mid();
        int  b;
        bit  seen;
        bit  done_seen;
        b         = 0;
        seen      = 1'b0;
        done_seen = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        len_aad_bytes = LEN_W'(32);
        len_pld_bytes = LEN_W'(0);
        aad_ready     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            if (done) done_seen = 1'b1;
            if (aad_valid) begin
                seen    = 1'b1;
                s_valid = 1'b0;
            end else begin
                s_valid = s_ready;
                s_data  = host_word(b);
                if (s_ready) b += 4;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reach_aad_send: got no aad_valid expected aad_valid within 20 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        if (done) done_seen = 1'b1;
        checks++;
        if ({busy, done, core_start, s_ready, aad_valid, din_valid, aad_keep, len_aad_bits} !== '0
            || aad_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got busy=%b aad_valid=%b aad_keep=%h len=%0d expected all 0",
                     busy, aad_valid, aad_keep, len_aad_bits);
        end
        rst_n     = 1'b1;
        aad_ready = 1'b1;
        @(negedge clk);
        if (done) done_seen = 1'b1;
        checks++;
        if (done_seen || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abandon: got done_seen=%b busy=%b expected 0/0", done_seen, busy);
        end
        do_frame(16, 0, 0, 1'b0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        hb            = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        len_aad_bytes = '0;
        len_pld_bytes = '0;
        s_valid       = 1'b0;
        s_data        = '0;
        aad_ready     = 1'b1;
        din_ready     = 1'b1;
        test_reset();
        test_frame();
        test_short_payload();
        test_empty();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
